// File: rtl/riscy_data_mem_responder_pkg.sv
// Shared types and constants for the RI5CY data-memory responder.
// Used by the response delay line and by the top level.
package riscy_mem_pkg;

    localparam int          MAX_LATENCY = 4;
    localparam logic [31:0] OOR_RDATA   = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        oor;
    } resp_t;

    // Replaces only the byte lanes whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        be_merge = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) be_merge[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

endpackage

// File: rtl/riscy_data_mem_responder_if.sv
// Core data-port bus: req/gnt request channel plus in-order rvalid/rdata return.
// No flow control on the return path; the core always accepts a response.
interface riscy_data_mem_responder_if;
    logic        data_req;
    logic        data_gnt;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/riscy_data_mem_responder_resp_pipe.sv
// LATENCY-deep shift register of responses; output appears LATENCY edges after input.
// Never stalls; flush_i clears every stage on the next rising edge.
module riscy_mem_resp_pipe
    import riscy_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk_i,
    input  logic  flush_i,
    input  resp_t in_resp_i,
    output resp_t out_resp_o
);

    resp_t [LATENCY-1:0] stage_q;
    resp_t [LATENCY-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_resp_i;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (flush_i) stage_d = '0;
    end

    always_ff @(posedge clk_i) begin
        stage_q <= stage_d;
    end

    assign out_resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/riscy_data_mem_responder.sv
// Word-array data memory for the RI5CY data port; rvalid follows each grant by LATENCY cycles.
// Grant drops on stall_i, on reset, or when MAX_OUTSTANDING responses are in flight with none retiring.
module riscy_data_mem_responder
    import riscy_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    riscy_data_mem_responder_if.slave      dbus,
    input  logic                           stall_i,
    input  logic                           pl_we_i,
    input  logic [ADDR_WIDTH-1:0]          pl_addr_i,
    input  logic [31:0]                    pl_wdata_i,
    output logic                           st_valid_o,
    output logic [31:0]                    st_addr_o,
    output logic [31:0]                    st_data_o,
    output logic [3:0]                     st_be_o,
    output logic                           oor_o,
    output logic [2:0]                     outstanding_o
);

    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic [29:0]           word_off;
    logic                  req_oor;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [31:0]           rd_word;
    logic                  retire;
    logic                  gnt;
    logic                  hs;
    logic                  st_wr_en;
    logic [31:0]           st_wr_dat;
    logic                  pl_wr_en;
    resp_t                 resp_in;
    resp_t                 resp_out;

    logic        st_valid_q, st_valid_d;
    logic [31:0] st_addr_q,  st_addr_d;
    logic [31:0] st_data_q,  st_data_d;
    logic [3:0]  st_be_q,    st_be_d;
    logic [2:0]  outstanding_q, outstanding_d;

    always_comb begin
        // Addresses below the base wrap to a huge offset, but the explicit compare keeps it obvious.
        word_off  = dbus.data_addr[31:2] - BASE_WORD;
        req_oor   = (dbus.data_addr[31:2] < BASE_WORD) | (|word_off[29:ADDR_WIDTH]);
        req_idx   = word_off[ADDR_WIDTH-1:0];
        rd_word   = mem_q[req_idx];

        retire    = resp_out.valid;
        gnt       = dbus.data_req & ~stall_i & ~rst_i &
                    ((outstanding_q < 3'(MAX_OUTSTANDING)) | retire);
        hs        = dbus.data_req & gnt;

        st_wr_en  = hs & dbus.data_we & ~req_oor;
        st_wr_dat = be_merge(rd_word, dbus.data_wdata, dbus.data_be);
        // A same-edge store to the preload target takes priority.
        pl_wr_en  = pl_we_i & ~(st_wr_en && (pl_addr_i == req_idx));

        resp_in.valid = hs;
        resp_in.oor   = hs & req_oor;
        resp_in.rdata = '0;
        if (hs && !dbus.data_we) resp_in.rdata = req_oor ? OOR_RDATA : rd_word;

        st_valid_d = st_wr_en;
        st_addr_d  = st_wr_en ? dbus.data_addr  : st_addr_q;
        st_data_d  = st_wr_en ? dbus.data_wdata : st_data_q;
        st_be_d    = st_wr_en ? dbus.data_be    : st_be_q;

        outstanding_d = outstanding_q;
        unique case ({hs, retire})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Array contents are deliberately left out of reset so preloads survive it.
    always_ff @(posedge clk_i) begin
        if (pl_wr_en) mem_q[pl_addr_i] <= pl_wdata_i;
        if (st_wr_en) mem_q[req_idx]   <= st_wr_dat;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_valid_q    <= 1'b0;
            st_addr_q     <= '0;
            st_data_q     <= '0;
            st_be_q       <= '0;
            outstanding_q <= '0;
        end else begin
            st_valid_q    <= st_valid_d;
            st_addr_q     <= st_addr_d;
            st_data_q     <= st_data_d;
            st_be_q       <= st_be_d;
            outstanding_q <= outstanding_d;
        end
    end

    riscy_mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk_i      (clk_i),
        .flush_i    (rst_i),
        .in_resp_i  (resp_in),
        .out_resp_o (resp_out)
    );

    assign dbus.data_gnt    = gnt;
    assign dbus.data_rvalid = resp_out.valid;
    assign dbus.data_rdata  = resp_out.valid ? resp_out.rdata : 32'h0;
    assign oor_o            = resp_out.valid & resp_out.oor;
    assign st_valid_o       = st_valid_q;
    assign st_addr_o        = st_addr_q;
    assign st_data_o        = st_data_q;
    assign st_be_o          = st_be_q;
    assign outstanding_o    = outstanding_q;

endmodule
